// File: rtl/l1_bus_arb_pkg.sv
// Shared types for the L1 two-requester bus arbiter.
package l1_bus_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    SERVE0,
    SERVE1
  } arb_state_t;

  typedef logic req_id_t;

  // Serving state for a given requester id.
  function automatic arb_state_t serve_state(input req_id_t id);
    return id ? SERVE1 : SERVE0;
  endfunction

endpackage

// File: rtl/generic_bus_if.sv
// Simple request/busy memory bus shared by the L1 caches and the memory side.
interface generic_bus_if;
  logic        ren;
  logic        wen;
  logic        busy;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  byte_en;

  // Slave view: receives requests, returns data and busy.
  modport generic_bus (
    input  ren, wen, addr, wdata, byte_en,
    output rdata, busy
  );

  // Master view: issues requests, consumes data and busy.
  modport cpu (
    input  rdata, busy,
    output ren, wen, addr, wdata, byte_en
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick between two requesters.
// When both are valid the one that did not win last time is chosen.
module rr_pick
  import l1_bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  req_id_t            last,
  output logic               gnt_valid,
  output req_id_t            gnt_id
);

  // Winner selection: lone requester wins, contention alternates.
  always_comb begin
    gnt_valid = |valid;
    if (&valid) begin
      gnt_id = ~last;
    end else begin
      gnt_id = valid[1];
    end
  end

endmodule

// File: rtl/l1_bus_arbiter.sv
// Round-robin arbiter sharing one generic_bus_if memory port between the
// I-cache (req0) and D-cache (req1). A grant is held for a whole transfer
// and every transfer costs one arbitration cycle in IDLE.
// Optional performance counters are built when L1_BUS_ARB_PERF_EN is defined.
module l1_bus_arbiter
  import l1_bus_arb_pkg::*;
#(
  parameter int unsigned FIRST_PRIO = 0,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  generic_bus_if.generic_bus   req0,
  generic_bus_if.generic_bus   req1,
  generic_bus_if.cpu           out
`ifdef L1_BUS_ARB_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] grant_cnt0,
  output logic [CNT_WIDTH-1:0] grant_cnt1,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  // Reject nonsensical configurations at elaboration.
  if (FIRST_PRIO > 1 || CNT_WIDTH == 0) begin : g_bad_param
    $error("l1_bus_arbiter: FIRST_PRIO must be 0/1 and CNT_WIDTH nonzero");
  end

  arb_state_t           state_q, state_d;
  req_id_t              last_q, last_d;
  logic [NUM_REQ-1:0]   valid;
  logic                 gnt_valid;
  req_id_t              gnt_id;

  // A requester is active whenever it asks to read or write.
  always_comb begin
    valid = {req1.ren | req1.wen, req0.ren | req0.wen};
  end

  rr_pick u_rr_pick (
    .valid     (valid),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Next state: arbitrate in IDLE, release on completion or abort.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = serve_state(gnt_id);
        end
      end
      SERVE0: begin
        if (!valid[0]) begin
          // Abort leaves the round-robin pointer untouched.
          state_d = IDLE;
        end else if (!out.busy) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      SERVE1: begin
        if (!valid[1]) begin
          state_d = IDLE;
        end else if (!out.busy) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      last_q  <= req_id_t'(~FIRST_PRIO[0]);
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Request mux toward memory and response demux toward the caches.
  // out.ren/wen depend only on state and requester inputs, never on out.busy.
  always_comb begin
    out.ren     = 1'b0;
    out.wen     = 1'b0;
    out.addr    = '0;
    out.wdata   = '0;
    out.byte_en = '0;
    req0.busy   = 1'b1;
    req0.rdata  = '0;
    req1.busy   = 1'b1;
    req1.rdata  = '0;
    unique case (state_q)
      SERVE0: begin
        out.ren     = req0.ren;
        out.wen     = req0.wen;
        out.addr    = req0.addr;
        out.wdata   = req0.wdata;
        out.byte_en = req0.byte_en;
        req0.busy   = out.busy;
        req0.rdata  = out.rdata;
      end
      SERVE1: begin
        out.ren     = req1.ren;
        out.wen     = req1.wen;
        out.addr    = req1.addr;
        out.wdata   = req1.wdata;
        out.byte_en = req1.byte_en;
        req1.busy   = out.busy;
        req1.rdata  = out.rdata;
      end
      default: ;
    endcase
  end

`ifdef L1_BUS_ARB_PERF_EN
  logic                 done0, done1, both;
  logic [CNT_WIDTH-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [CNT_WIDTH-1:0] grant_cnt1_q, grant_cnt1_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Counter events and wrapping increments.
  always_comb begin
    done0        = (state_q == SERVE0) && valid[0] && !out.busy;
    done1        = (state_q == SERVE1) && valid[1] && !out.busy;
    both         = &valid;
    grant_cnt0_d = grant_cnt0_q + (done0 ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
    grant_cnt1_d = grant_cnt1_q + (done1 ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
    stall_cnt_d  = stall_cnt_q + (both ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
  end

  // Performance counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign stall_cnt  = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // Requester dropped its request while granted and before busy fell.
  abort_a: assert property (@(posedge CLK) disable iff (!nRST)
    !((state_q == SERVE0 && !valid[0]) || (state_q == SERVE1 && !valid[1])))
    else $warning("l1_bus_arbiter: requester abandoned a granted transfer");

  // Simultaneous read and write is forwarded but is a protocol error.
  rw_a: assert property (@(posedge CLK) disable iff (!nRST)
    !(out.ren && out.wen))
    else $warning("l1_bus_arbiter: ren and wen asserted together");
`endif

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Scoreboard bench for l1_bus_arbiter: directed stimulus pushes expected
// completions (requester id, read data) and a negedge monitor checks them.
module tb_l1_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  generic_bus_if req0_if ();
  generic_bus_if req1_if ();
  generic_bus_if out_if ();

`ifdef L1_BUS_ARB_PERF_EN
  logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

  l1_bus_arbiter dut (
    .CLK  (clk),
    .nRST (rst_n),
    .req0 (req0_if),
    .req1 (req1_if),
    .out  (out_if)
`ifdef L1_BUS_ARB_PERF_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Memory BFM: busy for bfm_wait cycles per transfer, data from address.
  int bfm_wait = 0;
  int wcnt = 0;
  assign out_if.busy  = (wcnt < bfm_wait);
  assign out_if.rdata = {16'hdada, out_if.addr[15:0]};
  always @(posedge clk) begin
    if (!(out_if.ren | out_if.wen) || !out_if.busy) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  typedef struct {
    int          id;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int nvec = 0;
  int nerr = 0;
  int done_cnt = 0;

  task automatic expect_xfer(input int id, input logic [31:0] addr);
    exp_t e;
    e.id    = id;
    e.rdata = {16'hdada, addr[15:0]};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) until done_cnt reaches target; returns just after a posedge.
  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt >= target) break;
    end
    if (done_cnt < target) begin
      nvec++;
      nerr++;
      $display("FAIL timeout: completions %0d expected %0d", done_cnt, target);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every completion pops one expectation and compares it.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((req0_if.ren | req0_if.wen) && !req0_if.busy) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL grant: unexpected req0 completion, none expected");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.id != 0 || req0_if.rdata !== e.rdata) begin
            nerr++;
            $display("FAIL grant: got req0 rdata %h expected req%0d rdata %h",
                     req0_if.rdata, e.id, e.rdata);
          end
        end
        done_cnt++;
      end
      if ((req1_if.ren | req1_if.wen) && !req1_if.busy) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL grant: unexpected req1 completion, none expected");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.id != 1 || req1_if.rdata !== e.rdata) begin
            nerr++;
            $display("FAIL grant: got req1 rdata %h expected req%0d rdata %h",
                     req1_if.rdata, e.id, e.rdata);
          end
        end
        done_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    req0_if.ren = 0; req0_if.wen = 0; req0_if.addr = 0; req0_if.wdata = 0;
    req0_if.byte_en = 4'hf;
    req1_if.ren = 0; req1_if.wen = 0; req1_if.addr = 0; req1_if.wdata = 0;
    req1_if.byte_en = 4'hf;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_ren", {31'b0, out_if.ren}, 32'd0);
    chk("rst_out_wen", {31'b0, out_if.wen}, 32'd0);
    chk("rst_out_addr", out_if.addr, 32'd0);
    chk("rst_out_byte_en", {28'b0, out_if.byte_en}, 32'd0);
    chk("rst_req0_busy", {31'b0, req0_if.busy}, 32'd1);
    chk("rst_req1_busy", {31'b0, req1_if.busy}, 32'd1);
    chk("rst_req0_rdata", req0_if.rdata, 32'd0);
    rst_n = 1'b1;

    // 1: single read, zero-wait.
    base = done_cnt;
    expect_xfer(0, 32'h100);
    @(posedge clk); #1;
    req0_if.ren = 1; req0_if.addr = 32'h100;
    @(negedge clk);
    chk("t1_arb_cycle_busy", {31'b0, req0_if.busy}, 32'd1);
    chk("t1_arb_cycle_out_ren", {31'b0, out_if.ren}, 32'd0);
    @(negedge clk);
    chk("t1_data_cycle_busy", {31'b0, req0_if.busy}, 32'd0);
    chk("t1_out_addr", out_if.addr, 32'h100);
    chk("t1_out_byte_en", {28'b0, out_if.byte_en}, 32'hf);
    wait_done(base + 1, 10);
    #1 req0_if.ren = 0;

    // 2: contention right after reset alternates 0,1,0,1.
    do_reset();
    base = done_cnt;
    expect_xfer(0, 32'h100);
    expect_xfer(1, 32'h2004);
    expect_xfer(0, 32'h100);
    expect_xfer(1, 32'h2004);
    @(posedge clk); #1;
    req0_if.ren = 1; req0_if.addr = 32'h100;
    req1_if.wen = 1; req1_if.addr = 32'h2004; req1_if.wdata = 32'h1234_5678;
    wait_done(base + 4, 20);
    #1 req0_if.ren = 0; req1_if.wen = 0;

    // 3: slow slave on a req1 write while req0 waits.
    base = done_cnt;
    expect_xfer(1, 32'h3000);
    expect_xfer(0, 32'h100);
    bfm_wait = 5;
    @(posedge clk); #1;
    req1_if.wen = 1; req1_if.addr = 32'h3000; req1_if.wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req0_if.ren = 1; req0_if.addr = 32'h100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_loser_busy", {31'b0, req0_if.busy}, 32'd1);
      chk("t3_out_wdata", out_if.wdata, 32'hCAFE_F00D);
    end
    chk("t3_out_wen", {31'b0, out_if.wen}, 32'd1);
    wait_done(base + 1, 20);
    #1 req1_if.wen = 0; bfm_wait = 0;
    @(negedge clk);
    chk("t3_idle_gap_ren", {31'b0, out_if.ren}, 32'd0);
    @(negedge clk);
    chk("t3_req0_granted_ren", {31'b0, out_if.ren}, 32'd1);
    chk("t3_req0_granted_addr", out_if.addr, 32'h100);
    wait_done(base + 2, 10);
    #1 req0_if.ren = 0;

    // 4: req1 abandons its grant; pending req0 is served next.
    base = done_cnt;
    expect_xfer(0, 32'h100);
    bfm_wait = 5;
    @(posedge clk); #1;
    req1_if.ren = 1; req1_if.addr = 32'h4000;
    @(posedge clk); #1;
    req0_if.ren = 1;
    @(posedge clk); #1;
    req1_if.ren = 0; bfm_wait = 0;
    #1 chk("t4_abort_out_ren", {31'b0, out_if.ren}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t4_idle_out_ren", {31'b0, out_if.ren}, 32'd0);
    chk("t4_idle_req0_busy", {31'b0, req0_if.busy}, 32'd1);
    wait_done(base + 1, 10);
    #1 req0_if.ren = 0;

    // 5: async reset mid-SERVE0, then contention goes to req0 first.
    base = done_cnt;
    bfm_wait = 5;
    @(posedge clk); #1;
    req0_if.ren = 1; req0_if.addr = 32'h500;
    @(posedge clk);
    @(negedge clk);
    chk("t5_pre_reset_out_ren", {31'b0, out_if.ren}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_out_ren", {31'b0, out_if.ren}, 32'd0);
    chk("t5_reset_out_wen", {31'b0, out_if.wen}, 32'd0);
    req0_if.addr = 32'h100;
    req1_if.ren = 1; req1_if.addr = 32'h2004;
    bfm_wait = 0;
    expect_xfer(0, 32'h100);
    expect_xfer(1, 32'h2004);
    repeat (2) @(negedge clk);
    chk("t5_in_reset_req0_busy", {31'b0, req0_if.busy}, 32'd1);
    rst_n = 1'b1;
    wait_done(base + 2, 10);
    #1 req0_if.ren = 0; req1_if.ren = 0;

`ifdef L1_BUS_ARB_PERF_EN
    // 6: 3 req0 and 2 req1 transfers with 4 cycles of contention.
    do_reset();
    base = done_cnt;
    expect_xfer(0, 32'h100);
    expect_xfer(0, 32'h100);
    expect_xfer(1, 32'h2004);
    expect_xfer(0, 32'h100);
    expect_xfer(1, 32'h2004);
    @(posedge clk); #1;
    req0_if.ren = 1;
    wait_done(base + 2, 10);
    #1 req1_if.ren = 1;
    wait_done(base + 4, 10);
    #1 req0_if.ren = 0;
    wait_done(base + 5, 10);
    #1 req1_if.ren = 0;
    @(negedge clk);
    chk("t6_grant_cnt0", grant_cnt0, 32'd3);
    chk("t6_grant_cnt1", grant_cnt1, 32'd2);
    chk("t6_stall_cnt", stall_cnt, 32'd4);
`endif

    repeat (3) @(negedge clk);
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: %0d expected completions left, 0 required",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
